// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : freq_meter
// Description : Measures the period and high time of a slow asynchronous
//               input (e.g. a divided clock) in cycles of the 10 MHz
//               reference, flags lock when successive periods agree and
//               flags a sticky timeout when the input stops toggling.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_meter #(
  parameter int CNT_W  = 16,
  parameter int LOCK_N = 4,
  parameter int TOL    = 1,
  parameter int TMO    = 1000
) (
  input  logic             F10M,
  input  logic             RESET,
  input  logic             SIG_IN,
  output logic [CNT_W-1:0] PERIOD,
  output logic [CNT_W-1:0] HIGH_CNT,
  output logic             VALID,
  output logic             LOCK,
  output logic             TIMEOUT
);

  // Match counter only needs to reach LOCK_N-1 (LOCK_N >= 2).
  localparam int MATCH_W = $clog2(LOCK_N);

  localparam logic [CNT_W-1:0]   c_cnt_max   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   c_tmo       = CNT_W'(TMO);
  localparam logic [CNT_W-1:0]   c_tol       = CNT_W'(TOL);
  localparam logic [MATCH_W-1:0] c_match_max = MATCH_W'(LOCK_N - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } state_t;

  state_t               state_q,  state_d;
  logic                 s1_q,     s1_d;
  logic                 s2_q,     s2_d;
  logic                 s3_q,     s3_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [CNT_W-1:0]     hcnt_q,   hcnt_d;
  logic [CNT_W-1:0]     period_q, period_d;
  logic [CNT_W-1:0]     high_q,   high_d;
  logic                 valid_q,  valid_d;
  logic                 lock_q,   lock_d;
  logic                 tmo_q,    tmo_d;
  logic [MATCH_W-1:0]   match_q,  match_d;
  logic                 first_q,  first_d;

  logic                 w_rise;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic [CNT_W-1:0]     w_hcnt_inc;
  logic [CNT_W-1:0]     w_diff;
  logic                 w_in_tol;

  // Next-state logic: synchronizer, counters, measurement FSM and lock tracking.
  always_comb begin
    w_rise     = s2_q & ~s3_q;
    w_cnt_inc  = (cnt_q  == c_cnt_max) ? c_cnt_max : cnt_q  + 1'b1;
    w_hcnt_inc = (hcnt_q == c_cnt_max) ? c_cnt_max : hcnt_q + 1'b1;
    // Unsigned distance between the new period and the previous one, no wrap.
    w_diff     = (w_cnt_inc >= period_q) ? (w_cnt_inc - period_q) : (period_q - w_cnt_inc);
    w_in_tol   = (w_diff <= c_tol);

    s1_d     = SIG_IN;
    s2_d     = s1_q;
    s3_d     = s2_q;
    cnt_d    = w_rise ? '0 : w_cnt_inc;
    hcnt_d   = w_rise ? CNT_W'(1) : (s2_q ? w_hcnt_inc : hcnt_q);

    state_d  = state_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    lock_d   = lock_q;
    tmo_d    = tmo_q;
    match_d  = match_q;
    first_d  = first_q;

    case (state_q)
      ST_IDLE: begin
        if (w_rise) begin
          // Opening edge only; the first full period ends at the next rise.
          state_d = ST_MEAS;
          first_d = 1'b1;
        end else if (w_cnt_inc >= c_tmo) begin
          // No edge at all since reset/timeout: report a dead input.
          tmo_d   = 1'b1;
          lock_d  = 1'b0;
          match_d = '0;
        end
      end
      ST_MEAS: begin
        if (w_rise) begin
          // A rise wins over a coincident timeout threshold.
          period_d = w_cnt_inc;
          high_d   = hcnt_q;
          valid_d  = 1'b1;
          tmo_d    = 1'b0;
          first_d  = 1'b0;
          if (first_q || !w_in_tol) begin
            match_d = '0;
          end else if (match_q != c_match_max) begin
            match_d = match_q + 1'b1;
          end
          lock_d = (match_d == c_match_max);
        end else if (w_cnt_inc >= c_tmo) begin
          tmo_d   = 1'b1;
          lock_d  = 1'b0;
          match_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge F10M) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      lock_q   <= 1'b0;
      tmo_q    <= 1'b0;
      match_q  <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      lock_q   <= lock_d;
      tmo_q    <= tmo_d;
      match_q  <= match_d;
      first_q  <= first_d;
    end
  end

  assign PERIOD   = period_q;
  assign HIGH_CNT = high_q;
  assign VALID    = valid_q;
  assign LOCK     = lock_q;
  assign TIMEOUT  = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_freq_meter
// Description : Directed self-checking bench for freq_meter. Inputs change on
//               the falling reference edge, outputs are sampled there too.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_meter;

  localparam int CNT_W  = 16;
  localparam int LOCK_N = 4;
  localparam int TOL    = 1;
  localparam int TMO    = 1000;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_cnt;
  logic             valid;
  logic             lock;
  logic             tmo;

  int cyc       = 0;
  int n_pass    = 0;
  int n_checks  = 0;
  int last_rise = 0;
  int t0        = 0;
  int c5        = 0;

  typedef struct {
    int   cyc;
    int   per;
    int   hi;
    logic lk;
    logic to;
  } rec_t;

  rec_t recs[$];
  rec_t mon_r;

  int   alt_per [11] = '{20, 21, 20, 21, 20, 25, 20, 21, 20, 21, 20};
  logic alt_lock[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic p20_lock[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};

  freq_meter #(
    .CNT_W  (CNT_W),
    .LOCK_N (LOCK_N),
    .TOL    (TOL),
    .TMO    (TMO)
  ) dut (
    .F10M     (clk),
    .RESET    (reset_n),
    .SIG_IN   (sig_in),
    .PERIOD   (period),
    .HIGH_CNT (high_cnt),
    .VALID    (valid),
    .LOCK     (lock),
    .TIMEOUT  (tmo)
  );

  // 10 MHz reference.
  always #50 clk = ~clk;

  // Reference cycle counter used to time events.
  always @(posedge clk) cyc <= cyc + 1;

  // Log every VALID pulse together with the outputs visible in that cycle.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && valid === 1'b1) begin
      mon_r.cyc = cyc;
      mon_r.per = int'(period);
      mon_r.hi  = int'(high_cnt);
      mon_r.lk  = lock;
      mon_r.to  = tmo;
      recs.push_back(mon_r);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic hold(input logic v, input int n);
    sig_in = v;
    repeat (n) @(negedge clk);
  endtask

  // One input period starting with a rising edge at the current falling edge.
  task automatic pulse(input int hi, input int lo);
    last_rise = cyc;
    hold(1'b1, hi);
    hold(1'b0, lo);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Hold reset for n cycles with the input toggling, check the cleared
  // outputs, then release with the input low.
  task automatic apply_reset(input string tag, input int n);
    reset_n = 1'b0;
    repeat (n) begin
      sig_in = ~sig_in;
      @(negedge clk);
    end
    check_val({tag, "_period"}, 32'(period),   0);
    check_val({tag, "_high"},   32'(high_cnt), 0);
    check_val({tag, "_valid"},  32'(valid),    0);
    check_val({tag, "_lock"},   32'(lock),     0);
    check_val({tag, "_tmo"},    32'(tmo),      0);
    sig_in  = 1'b0;
    reset_n = 1'b1;
  endtask

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    sig_in  = 1'b0;
    @(negedge clk);

    // Reset with a toggling input, then no edges: timeout, no VALID.
    apply_reset("rst1", 2);
    repeat (TMO - 5) @(negedge clk);
    check_val("idle_tmo_early", 32'(tmo), 0);
    repeat (8) @(negedge clk);
    check_val("idle_tmo", 32'(tmo), 1);
    check_val("idle_no_valid", 32'(recs.size()), 0);

    // 500 kHz, 50 % duty, starting from the timed-out state.
    t0 = cyc;
    pulse(10, 10);
    check_val("p20_tmo_held", 32'(tmo), 1);
    check_val("p20_first_no_valid", 32'(recs.size()), 0);
    repeat (4) pulse(10, 10);
    check_val("p20_nvalid", 32'(recs.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < recs.size()) begin
        check_val("p20_period", 32'(recs[i].per), 20);
        check_val("p20_high",   32'(recs[i].hi),  10);
        check_val("p20_lock",   32'(recs[i].lk),  32'(p20_lock[i]));
        check_val("p20_tmo",    32'(recs[i].to),  0);
        if (i == 0) check_val("p20_first_time", 32'(recs[i].cyc), 32'(t0 + 23));
        else        check_val("p20_spacing", 32'(recs[i].cyc - recs[i-1].cyc), 20);
      end
    end
    recs.delete();

    // Input stops low: timeout TMO cycles after the last rise was registered.
    c5 = last_rise;
    wait_cyc(c5 + 2 + TMO);
    check_val("stop_tmo_before", 32'(tmo),  0);
    check_val("stop_lock_before", 32'(lock), 1);
    @(negedge clk);
    check_val("stop_tmo",    32'(tmo),      1);
    check_val("stop_lock",   32'(lock),     0);
    check_val("stop_period", 32'(period),   20);
    check_val("stop_high",   32'(high_cnt), 10);
    check_val("stop_no_valid", 32'(recs.size()), 0);

    // Restart with periods alternating 20/21, one 25 outlier, then relock.
    pulse(10, alt_per[0] - 10);
    check_val("alt_tmo_held", 32'(tmo), 1);
    check_val("alt_first_no_valid", 32'(recs.size()), 0);
    for (int i = 1; i < 11; i++) pulse(10, alt_per[i] - 10);
    check_val("alt_nvalid", 32'(recs.size()), 10);
    for (int i = 0; i < 10; i++) begin
      if (i < recs.size()) begin
        check_val("alt_period", 32'(recs[i].per), 32'(alt_per[i]));
        check_val("alt_high",   32'(recs[i].hi),  10);
        check_val("alt_lock",   32'(recs[i].lk),  32'(alt_lock[i]));
        check_val("alt_tmo",    32'(recs[i].to),  0);
      end
    end
    recs.delete();

    // 25 % duty, period 40.
    apply_reset("rst2", 2);
    repeat (3) pulse(10, 30);
    check_val("d25_nvalid", 32'(recs.size()), 2);
    for (int i = 0; i < 2; i++) begin
      if (i < recs.size()) begin
        check_val("d25_period", 32'(recs[i].per), 40);
        check_val("d25_high",   32'(recs[i].hi),  10);
        check_val("d25_lock",   32'(recs[i].lk),  0);
      end
    end
    recs.delete();

    // Reset in the middle of a period discards it; two fresh rises needed.
    pulse(10, 15);
    check_val("mid_nvalid", 32'(recs.size()), 1);
    if (recs.size() > 0) check_val("mid_period", 32'(recs[0].per), 40);
    recs.delete();
    apply_reset("rst3", 2);
    pulse(10, 30);
    check_val("post_rst_one_rise", 32'(recs.size()), 0);
    pulse(10, 30);
    check_val("post_rst_nvalid", 32'(recs.size()), 1);
    if (recs.size() > 0) begin
      check_val("post_rst_period", 32'(recs[0].per), 40);
      check_val("post_rst_high",   32'(recs[0].hi),  10);
      check_val("post_rst_lock",   32'(recs[0].lk),  0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Receiving end of the clock-divider chain: samples a divided clock (e.g. the 500 kHz output of the divider) against the 10 MHz reference.
- Measures its period and high time in reference cycles, and flags lock when successive periods agree.
- Flags timeout when the input stops toggling.
- Used on-board and in benches to check divider outputs without a scope.

Parameters:
- CNT_W, 16: width of period/high-time counters and outputs.
- LOCK_N, 4: consecutive in-tolerance measurements required to assert LOCK (≥2).
- TOL, 1: max absolute difference, in reference cycles, between consecutive periods still counted as a match.
- TMO, 1000: reference cycles without a rising edge before timeout (≤ 2^CNT_W−1).

Ports:
- F10M  in  1  reference clock (10 MHz); all logic on rising edge.
- RESET  in  1  reset, synchronous, active-low.
- SIG_IN  in  1  measured signal, asynchronous to F10M.
- PERIOD  out  CNT_W  last measured period, reference cycles.
- HIGH_CNT  out  CNT_W  high time of that period, reference cycles.
- VALID  out  1  one-cycle pulse when PERIOD/HIGH_CNT update.
- LOCK  out  1  stable-frequency flag.
- TIMEOUT  out  1  sticky no-edge flag.

Behaviour:
- Reset is synchronous, active-low. While RESET=0 at a rising F10M edge, all registers clear:
  - PERIOD=0, HIGH_CNT=0, VALID=0, LOCK=0, TIMEOUT=0.
  - Synchronizer flops = 0; state = IDLE; internal counters = 0.
  - Reset mid-measurement discards the partial measurement.
- Input path: 2-flop synchronizer s1→s2, plus history flop s3.
  - Rising edge event rise = s2 & ~s3.
  - Latency from SIG_IN transition to rise is 2–3 F10M cycles.
  - A high SIG_IN at reset release is seen as a rising edge.
- Counters:
  - cnt: set to 0 on a rise cycle, else +1, saturating at 2^CNT_W−1.
  - hcnt: set to 1 on a rise cycle, else +1 while s2=1, hold while s2=0; saturates.
- FSM:
  - IDLE: wait for rise. On rise → MEAS, counters start, no VALID.
  - MEAS, on rise:
    - PERIOD<=cnt+1 and HIGH_CNT<=hcnt.
    - VALID=1 for exactly the following cycle, in which the new values are already visible.
    - TIMEOUT<=0; stay in MEAS.
  - MEAS, when cnt+1 reaches TMO without a rise: TIMEOUT<=1, LOCK<=0, match count<=0, → IDLE. PERIOD/HIGH_CNT hold their last values.
  - IDLE, on a rise while TIMEOUT=1: TIMEOUT stays 1 until the first VALID after re-entering MEAS.
- Lock:
  - On each measurement, compare the new period with the previous PERIOD. |new−old| ≤ TOL counts as a match, and the comparison uses unsigned difference without wrap.
  - Match: match count +1, saturating at LOCK_N−1.
  - Mismatch: match count <=0, and LOCK<=0 in the same cycle VALID rises.
  - The first measurement after IDLE or reset always resets the match count to 0.
  - LOCK<=1 when match count reaches LOCK_N−1, i.e. after LOCK_N consecutive consistent periods. It updates together with VALID.
- Simultaneous events: a rise in the same cycle as the timeout threshold is treated as a rise; timeout is not asserted.
- Duty: HIGH_CNT ≤ PERIOD always. A constant-high input never produces a second rise and times out.

Test Plan:
- RESET=0 for 2 cycles with SIG_IN toggling → all outputs 0; after release with no input edges, VALID never pulses and TIMEOUT=1 after TMO+3 cycles.
- SIG_IN = 500 kHz, 50 % duty (20 cycles) → first VALID at the second rising edge with PERIOD=20, HIGH_CNT=10; VALID repeats every 20 cycles; LOCK=1 coincident with the 4th VALID.
- Period alternating 20/21 cycles (TOL=1) → LOCK asserts after 4 VALIDs and stays 1. Then one 25-cycle period → LOCK=0 on that VALID; relocks after 4 further in-tolerance periods.
- 500 kHz input stopped low → TIMEOUT=1 and LOCK=0 exactly TMO cycles after the last rise; PERIOD stays 20. Restart → TIMEOUT clears at the first VALID (second rise).
- 25 % duty, period 40 → PERIOD=40, HIGH_CNT=10. Assert RESET mid-period → outputs 0, and the next VALID appears only after two fresh rises.
